// File: rtl/count_seq_pkg.sv
// Shared constants and state encoding for the count-sequence controller slice.
package count_seq_pkg;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned ST_W  = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] IDLE = 2'd0;
  localparam logic [ST_W-1:0] LOAD = 2'd1;
  localparam logic [ST_W-1:0] RUN  = 2'd2;
  localparam logic [ST_W-1:0] DONE = 2'd3;

endpackage

// File: rtl/updown_cnt3_core.sv
// 3-bit modulo-8 up/down counter with synchronous load and a combinational wrap flag.
module updown_cnt3_core
  import count_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_in,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_q,
  output logic             wrap_c
);

  // A load always wins, so a wrap is only flagged on a genuine step.
  assign wrap_c = en && !load && (up ? (cnt_q == '1) : (cnt_q == '0));

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= up ? (cnt_q + CNT_W'(1)) : (cnt_q - CNT_W'(1));
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Runs a commanded start->end count for cmd_loops+1 passes, with hold, abort
// and registered pass/sequence/wrap pulses.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned LOOP_W = 2
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_start,
  input  logic [CNT_W-1:0]  cmd_end,
  input  logic              cmd_up,
  input  logic [LOOP_W-1:0] cmd_loops,
  input  logic              hold_in,
  input  logic              abort_in,
  output logic [CNT_W-1:0]  cnt_q,
  output logic              busy,
  output logic              pass_done,
  output logic              seq_done,
  output logic              wrap_out
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  start_r;
  logic [CNT_W-1:0]  end_r;
  logic              up_r;
  logic [LOOP_W-1:0] loops_r;

  logic cap_en;
  logic ld_en;
  logic step_en;
  logic rem_dec;
  logic pass_nxt;
  logic seq_nxt;
  logic wrap_c;

  updown_cnt3_core u_cnt (
    .clk      (clk),
    .reset_in (reset_in),
    .load     (ld_en),
    .en       (step_en),
    .up       (up_r),
    .load_val (start_r),
    .cnt_q    (cnt_q),
    .wrap_c   (wrap_c)
  );

  // Next-state and per-cycle control decode; abort outranks hold.
  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    ld_en     = 1'b0;
    step_en   = 1'b0;
    rem_dec   = 1'b0;
    pass_nxt  = 1'b0;
    seq_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cap_en    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort_in) begin
          state_nxt = IDLE;
        end else begin
          ld_en     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_in) begin
          state_nxt = IDLE;
        end else if (!hold_in) begin
          if (cnt_q != end_r) begin
            step_en = 1'b1;
          end else begin
            pass_nxt = 1'b1;
            if (loops_r == '0) begin
              seq_nxt   = 1'b1;
              state_nxt = DONE;
            end else begin
              rem_dec   = 1'b1;
              state_nxt = LOAD;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      seq_done  <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      pass_done <= pass_nxt;
      seq_done  <= seq_nxt;
      wrap_out  <= wrap_c;
    end
  end

  // Captured command; loops_r doubles as the remaining-pass counter.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      start_r <= '0;
      end_r   <= '0;
      up_r    <= 1'b0;
      loops_r <= '0;
    end else if (cap_en) begin
      start_r <= cmd_start;
      end_r   <= cmd_end;
      up_r    <= cmd_up;
      loops_r <= cmd_loops;
    end else if (rem_dec) begin
      loops_r <= loops_r - LOOP_W'(1);
    end
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter LOOP_W, default 2, width of the pass-repeat field; the sequence runs cmd_loops+1 passes.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset_in  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at a rising edge.
REQ-006 cmd_start  in  3  first counter value of each pass.
REQ-007 cmd_end  in  3  terminal counter value of each pass.
REQ-008 cmd_up  in  1  direction: 1 = increment, 0 = decrement.
REQ-009 cmd_loops  in  LOOP_W  pass count minus one.
REQ-010 hold_in  in  1  freeze counting while high.
REQ-011 abort_in  in  1  terminate the active sequence.
REQ-012 cnt_q  out  3  current counter value.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 pass_done  out  1  one-cycle pulse per completed pass.
REQ-015 seq_done  out  1  one-cycle pulse when all passes are complete.
REQ-016 wrap_out  out  1  one-cycle pulse on a modulo-8 wrap step.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN and DONE; cmd_ready SHALL equal (state==IDLE).
REQ-018 In IDLE, an accepted command SHALL capture cmd_start, cmd_end, cmd_up and cmd_loops, and the next state SHALL be LOAD.
REQ-019 In LOAD, the counter SHALL be loaded with the captured start value at the edge, and the next state SHALL be RUN.
REQ-020 In RUN with hold_in=1, cnt_q, the pass counter and the state SHALL be unchanged.
REQ-021 In RUN with hold_in=0 and cnt_q!=end, cnt_q SHALL step by +1 or -1 modulo 8.
REQ-022 In RUN with hold_in=0 and cnt_q==end, cnt_q SHALL hold and pass_done SHALL pulse in the following cycle.
REQ-023 At that RUN cycle, the next state SHALL be DONE if the remaining-pass count is 0; otherwise the count SHALL decrement and the next state SHALL be LOAD.
REQ-024 start==end SHALL complete the pass at the first RUN cycle, with zero steps.
REQ-025 wrap_out SHALL pulse in the cycle after a 7->0 step (up) or a 0->7 step (down); loads never assert wrap_out.
REQ-026 DONE SHALL last exactly one cycle with seq_done=1, then the next state SHALL be IDLE; cnt_q SHALL retain the end value.
REQ-027 abort_in=1 in LOAD, RUN or DONE SHALL force the next state to IDLE and hold cnt_q.
REQ-028 After an abort, no further pass_done or seq_done SHALL occur for that command; abort SHALL take priority over hold_in.
REQ-029 abort_in in IDLE SHALL have no effect.
REQ-030 pass_done, seq_done and wrap_out SHALL be registered outputs.

Reset
REQ-031 reset_in low SHALL immediately force state=IDLE, cnt_q=0, busy=0, pass_done=seq_done=wrap_out=0, and clear all captured command registers.
REQ-032 A reset asserted mid-sequence SHALL discard the command, with no completion pulses.
REQ-033 After release, cmd_ready SHALL be 1 at the first rising edge.

Structure
REQ-034 Package count_seq_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DONE) and the constant CNT_W=3.
REQ-035 Sub-module updown_cnt3_core SHALL implement the 3-bit counter with load, enable, up/down, wrap flag and asynchronous active-low reset.
REQ-036 count_seq_ctrl SHALL contain only the FSM, the command registers, the pass counter and the output pulse registers.

Verification
REQ-037 Command (start=2, end=5, up, loops=0) accepted at edge 0 -> cnt_q=2,3,4,5 after edges 1-4; pass_done and seq_done high after edge 5; cmd_ready=1 after edge 6.
REQ-038 Command (start=6, end=1, up, loops=1) -> two passes of 6,7,0,1; wrap_out pulses once per pass; two pass_done pulses; one seq_done pulse.
REQ-039 Command (start=1, end=6, down) -> sequence 1,0,7,6; wrap_out after the 0->7 step.
REQ-040 Command (start=end=3) -> pass_done and seq_done with no counter step; wrap_out stays 0.
REQ-041 hold_in high for 3 cycles at cnt_q=4 -> cnt_q=4 for 3 cycles, completion delayed by exactly 3 cycles.
REQ-042 abort_in while cnt_q=3 in RUN -> IDLE next cycle, cnt_q=3, no seq_done; reset_in low mid-RUN -> cnt_q=0 and busy=0 asynchronously.
